// File: rtl/register_file_sb.sv
// Parametrised two-read/one-write register file with a per-register busy scoreboard.
// Reads, bypass and ready are combinational; storage and scoreboard update on the rising edge.
module register_file_sb #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned AW       = 2,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         ra_a,
    input  logic [AW-1:0]         ra_b,
    input  logic [AW-1:0]         wa,
    input  logic [WIDTH-1:0]      wd,
    input  logic                  we,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    output logic [WIDTH-1:0]      rd_a,
    output logic [WIDTH-1:0]      rd_b,
    output logic                  rdy_a,
    output logic                  rdy_b,
    output logic [(2**AW)-1:0]    busy
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam bit          HAS_Z = (ZERO_REG != 0);
    localparam bit          HAS_B = (BYPASS != 0);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_ok;

    // A write to R0 is dropped when R0 is hardwired to zero.
    assign wr_ok = we && !(HAS_Z && (wa == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wa] <= wd;
        end
    end

    // Reserve beats a same-edge write: that write belongs to the previous producer.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (rsv_en && (rsv_addr == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else if (we && (wa == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
        if (HAS_Z) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    // Read ports: zero register overrides bypass, bypass overrides storage.
    always_comb begin
        rd_a  = regs[ra_a];
        rd_b  = regs[ra_b];
        rdy_a = ~busy_q[ra_a];
        rdy_b = ~busy_q[ra_b];
        if (HAS_B && wr_ok && (wa == ra_a)) begin
            rd_a = wd;
        end
        if (HAS_B && wr_ok && (wa == ra_b)) begin
            rd_b = wd;
        end
        if (HAS_B && we && (wa == ra_a)) begin
            rdy_a = 1'b1;
        end
        if (HAS_B && we && (wa == ra_b)) begin
            rdy_b = 1'b1;
        end
        if (HAS_Z && (ra_a == '0)) begin
            rd_a  = '0;
            rdy_a = 1'b1;
        end
        if (HAS_Z && (ra_b == '0)) begin
            rd_b  = '0;
            rdy_b = 1'b1;
        end
        if (!rst) begin
            rd_a  = '0;
            rd_b  = '0;
            rdy_a = 1'b1;
            rdy_b = 1'b1;
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: two configurations (plain+bypass, zero-reg without bypass)
// driven in parallel and compared against an array-based reference model.
module tb_register_file_sb;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned VW    = 2 * WIDTH + 2 + DEPTH;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [AW-1:0]    ra_a, ra_b, wa, rsv_addr;
    logic [WIDTH-1:0] wd;
    logic             we, rsv_en;

    logic [WIDTH-1:0] rd_a0, rd_b0, rd_a1, rd_b1;
    logic             rdy_a0, rdy_b0, rdy_a1, rdy_b1;
    logic [DEPTH-1:0] busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-configuration model state and options (cfg0: ZERO_REG=0 BYPASS=1, cfg1: ZERO_REG=1 BYPASS=0).
    bit               cfg_zr [2] = '{1'b0, 1'b1};
    bit               cfg_bp [2] = '{1'b1, 1'b0};
    logic [WIDTH-1:0] m_reg  [2][DEPTH];
    bit               m_busy [2][DEPTH];

    always #5 clk = ~clk;

    register_file_sb #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(0), .BYPASS(1)) dut0 (
        .clk(clk), .rst(rst_n), .ra_a(ra_a), .ra_b(ra_b), .wa(wa), .wd(wd), .we(we),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_a(rd_a0), .rd_b(rd_b0),
        .rdy_a(rdy_a0), .rdy_b(rdy_b0), .busy(busy0)
    );

    register_file_sb #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .clk(clk), .rst(rst_n), .ra_a(ra_a), .ra_b(ra_b), .wa(wa), .wd(wd), .we(we),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_a(rd_a1), .rd_b(rd_b1),
        .rdy_a(rdy_a1), .rdy_b(rdy_b1), .busy(busy1)
    );

    function automatic logic [VW-1:0] act(input int c);
        if (c == 0) return {rd_a0, rd_b0, rdy_a0, rdy_b0, busy0};
        return {rd_a1, rd_b1, rdy_a1, rdy_b1, busy1};
    endfunction

    function automatic logic [WIDTH-1:0] m_rd(input int c, input logic [AW-1:0] a);
        if (cfg_zr[c] && a == 0) return '0;
        if (cfg_bp[c] && we && wa == a) return wd;
        return m_reg[c][a];
    endfunction

    function automatic logic m_rdy(input int c, input logic [AW-1:0] a);
        if (cfg_zr[c] && a == 0) return 1'b1;
        return !m_busy[c][a] || (cfg_bp[c] && we && wa == a);
    endfunction

    function automatic logic [VW-1:0] exp_vec(input int c);
        logic [DEPTH-1:0] b;
        if (!rst_n) return {{(2 * WIDTH){1'b0}}, 2'b11, {DEPTH{1'b0}}};
        for (int i = 0; i < int'(DEPTH); i++) b[i] = m_busy[c][i];
        return {m_rd(c, ra_a), m_rd(c, ra_b), m_rdy(c, ra_a), m_rdy(c, ra_b), b};
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < int'(DEPTH); i++) begin
                m_reg[c][i]  = '0;
                m_busy[c][i] = 1'b0;
            end
    endtask

    // Edge behaviour: the write clears busy, then a reserve sets it (so reserve wins).
    task automatic model_step();
        for (int c = 0; c < 2; c++) begin
            if (we && !(cfg_zr[c] && wa == 0)) m_reg[c][wa] = wd;
            if (we) m_busy[c][wa] = 1'b0;
            if (rsv_en) m_busy[c][rsv_addr] = 1'b1;
            if (cfg_zr[c]) m_busy[c][0] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic idle();
        we = 1'b0; rsv_en = 1'b0; wa = '0; wd = '0; rsv_addr = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_clear();
        tick(); tick();
        for (int a = 0; a < 4; a++) begin
            ra_a = AW'(a); ra_b = AW'(3 - a); #1;
            for (int c = 0; c < 2; c++) begin
                n_checks++;
                if (act(c) !== exp_vec(c) || act(c) !== {8'h00, 2'b11, 4'b0000}) begin
                    n_fail++;
                    $display("FAIL reset cfg%0d addr%0d got %h expected %h", c, a, act(c), exp_vec(c));
                end
            end
        end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_write_sweep();
        logic [WIDTH-1:0] vals [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; wa = AW'(i); wd = vals[i];
            tick();
        end
        idle();
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
                ra_a = AW'(a); ra_b = AW'(b); #1;
                for (int c = 0; c < 2; c++) begin
                    n_checks++;
                    if (act(c) !== exp_vec(c)) begin
                        n_fail++;
                        $display("FAIL write_sweep cfg%0d ra_a=%0d ra_b=%0d got %h expected %h",
                                 c, a, b, act(c), exp_vec(c));
                    end
                end
            end
    endtask

    task automatic test_bypass();
        we = 1'b1; wa = 2'd2; wd = 4'b1111; ra_a = 2'd2; ra_b = 2'd0; #1;
        n_checks++;
        if (rd_a0 !== 4'b1111 || rd_a1 !== 4'b0010) begin
            n_fail++;
            $display("FAIL bypass_same_cycle got %b/%b expected 1111/0010", rd_a0, rd_a1);
        end
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (act(c) !== exp_vec(c)) begin
                n_fail++;
                $display("FAIL bypass cfg%0d got %h expected %h", c, act(c), exp_vec(c));
            end
        end
        tick();
        idle(); #1;
        n_checks++;
        if (rd_a0 !== 4'b1111 || rd_a1 !== 4'b1111) begin
            n_fail++;
            $display("FAIL bypass_after_edge got %b/%b expected 1111/1111", rd_a0, rd_a1);
        end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_addr = 2'd3; ra_a = 2'd3; ra_b = 2'd0;
        tick();
        idle(); #1;
        n_checks++;
        if (busy0 !== 4'b1000 || rdy_a0 !== 1'b0 || rdy_a1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reserve got busy=%b rdy=%b/%b expected 1000 0/0", busy0, rdy_a0, rdy_a1);
        end
        we = 1'b1; wa = 2'd3; wd = 4'b0101; #1;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (act(c) !== exp_vec(c)) begin
                n_fail++;
                $display("FAIL release_same_cycle cfg%0d got %h expected %h", c, act(c), exp_vec(c));
            end
        end
        tick();
        idle(); #1;
        n_checks++;
        if (busy0 !== 4'b0000 || busy1 !== 4'b0000 || rd_a0 !== 4'b0101) begin
            n_fail++;
            $display("FAIL release got busy=%b/%b rd=%b expected 0000/0000 0101", busy0, busy1, rd_a0);
        end
    endtask

    task automatic test_collision();
        rsv_en = 1'b1; rsv_addr = 2'd1; we = 1'b1; wa = 2'd1; wd = 4'b0011;
        tick();
        idle(); ra_a = 2'd1; ra_b = 2'd1; #1;
        n_checks++;
        if (rd_a0 !== 4'b0011 || busy0[1] !== 1'b1 || busy1[1] !== 1'b1 || rdy_b0 !== 1'b0) begin
            n_fail++;
            $display("FAIL collision got rd=%b busy=%b/%b rdy=%b expected 0011 1/1 0",
                     rd_a0, busy0[1], busy1[1], rdy_b0);
        end
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (act(c) !== exp_vec(c)) begin
                n_fail++;
                $display("FAIL collision_model cfg%0d got %h expected %h", c, act(c), exp_vec(c));
            end
        end
        // Reserving R0 must be ignored only when R0 is hardwired.
        rsv_en = 1'b1; rsv_addr = 2'd0;
        tick();
        idle(); ra_a = 2'd0; #1;
        n_checks++;
        if (busy0[0] !== 1'b1 || busy1[0] !== 1'b0 || rdy_a1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reserve_r0 got %b/%b rdy=%b expected 1/0 1", busy0[0], busy1[0], rdy_a1);
        end
        we = 1'b1; wa = 2'd0; wd = 4'b0110;
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom); wa = AW'($urandom); wd = WIDTH'($urandom);
            rsv_en = 1'($urandom_range(0, 2) == 0); rsv_addr = AW'($urandom);
            ra_a = AW'($urandom); ra_b = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            #1;
            for (int c = 0; c < 2; c++) begin
                n_checks++;
                if (act(c) !== exp_vec(c)) begin
                    n_fail++;
                    $display("FAIL random cfg%0d iter%0d got %h expected %h", c, n, act(c), exp_vec(c));
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        we = 1'b1; wa = 2'd0; wd = 4'b0000; tick();   // clear stale state on both configs
        for (int i = 1; i < 4; i++) begin we = 1'b1; wa = AW'(i); wd = 4'b0000; tick(); end
        idle();
        rsv_en = 1'b1; rsv_addr = 2'd1; tick();
        rsv_addr = 2'd2; tick();
        idle(); ra_a = 2'd1; ra_b = 2'd2; #1;
        n_checks++;
        if (busy0 !== 4'b0110 || busy1 !== 4'b0110) begin
            n_fail++;
            $display("FAIL async_setup got %b/%b expected 0110/0110", busy0, busy1);
        end
        we = 1'b1; wa = 2'd2; wd = 4'b1010;
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (busy0 !== 4'b0000 || busy1 !== 4'b0000 || rd_b0 !== 4'b0000 ||
            rdy_a0 !== 1'b1 || rdy_b0 !== 1'b1) begin
            n_fail++;
            $display("FAIL async_clear got busy=%b/%b rd_b=%b rdy=%b%b expected 0000/0000 0000 11",
                     busy0, busy1, rd_b0, rdy_a0, rdy_b0);
        end
        tick();
        #2;
        rst_n = 1'b1;
        idle();
        for (int a = 0; a < 4; a++) begin
            ra_a = AW'(a); ra_b = AW'(a); #1;
            for (int c = 0; c < 2; c++) begin
                n_checks++;
                if (act(c) !== exp_vec(c) || act(c) !== {8'h00, 2'b11, 4'b0000}) begin
                    n_fail++;
                    $display("FAIL async_no_write cfg%0d addr%0d got %h expected %h",
                             c, a, act(c), exp_vec(c));
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ra_a = '0; ra_b = '0;
        idle();
        test_reset();
        test_write_sweep();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
